uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter's byte-stream input (data/valid/ready, 8-bit) between N_REQ requesters, e.g. CPU console, debug monitor, trace unit.
- Round-robin arbitration at packet granularity: a grant is held until the requester's last byte or until MAX_BURST bytes have been sent.
- A one-entry output register sits between the requester mux and the transmitter, so the arbiter adds a 1-cycle latency.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MAX_BURST, 64, maximum bytes per grant before forced release (1..256).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_data  in  N_REQ x 8  byte from each requester
- req_valid  in  N_REQ  requester i has a byte
- req_last  in  N_REQ  byte from requester i ends its packet
- req_ready  out  N_REQ  byte from requester i accepted this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts (its idle flag)
- grant_id  out  $clog2(N_REQ)  current or last granted requester
- busy  out  1  state != IDLE or tx_valid

Behaviour:
- Interface: one clock, `clock`; `reset` is synchronous, active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
  - tx_valid=0, tx_data=0, req_ready all 0, busy=0.
- Output register:
  - Is free when !tx_valid || tx_ready.
  - Transfer on tx_valid & tx_ready.
  - tx_data holds stable while tx_valid & !tx_ready.
- IDLE:
  - Search req_valid starting at index rr_ptr, wrapping modulo N_REQ; the first set index wins.
  - On a hit: grant_id<=winner, burst_cnt<=0, state<=SEND.
  - No byte is accepted in the arbitration cycle.
- SEND:
  - req_ready[grant_id] = reg free; all other req_ready are 0.
  - On req_valid[g] & req_ready[g]: load tx_data, set tx_valid, burst_cnt++.
  - Release when the accepted byte has req_last, or when burst_cnt reaches MAX_BURST-1 on accept. Then state<=IDLE and rr_ptr<=(grant_id+1) mod N_REQ.
  - If req_valid[g] drops mid-packet, stay in SEND and wait. There is no timeout unless MAX_BURST is reached.
- Fairness: a requester that keeps req_valid high waits at most (N_REQ-1) grants.
- Throughput:
  - 1 idle arbitration cycle per packet.
  - Back-to-back bytes within a packet whenever tx_ready is high. With a UART, tx_ready is low for most of each frame, so this is not a bottleneck.
- Simultaneous events: register drain and reload in the same cycle are allowed, since free includes tx_ready.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr wraps explicitly at N_REQ; power-of-two N_REQ is not required.
- Reset mid-packet: the pending byte in the output register is dropped and the grant is cleared. Requesters must resend.

Optional Feature:
- Macro: UART_TX_ARBITER_TAG_EN.
- Defined:
  - On each grant, the FSM goes IDLE -> TAG -> SEND.
  - TAG loads the byte 8'hF0 | grant_id into the output register when it is free, then enters SEND.
  - The tag does not count toward burst_cnt; req_ready is 0 during TAG.
  - The host demultiplexes streams by tag.
- Undefined: the TAG state and its logic are absent; IDLE goes directly to SEND.

Decomposition:
- Package uart_pkg:
  - typedef byte_t (logic[7:0]).
  - enum arb_state_t {IDLE, TAG, SEND}; the TAG encoding is kept even when the feature is off.
  - localparam TAG_PREFIX = 4'hF.
- Sub-module rr_pick: combinational round-robin priority picker, taking req vector and rr_ptr and producing winner index and hit. It is reusable by other arbiters.
- The top instantiates rr_pick plus the FSM and output register.

Test Plan:
- Single requester: req1 sends 3 bytes 41,42,43 (last on 43), tx_ready always 1 -> tx sees 41,42,43 on consecutive cycles starting 2 cycles after req_valid; grant_id=1; busy falls 1 cycle after 43 is accepted.
- Round-robin: req0, req1 and req2 each hold a 2-byte packet from the same cycle, with rr_ptr=0 -> output order is req0, req1, req2 packets; rr_ptr ends at 0.
- Backpressure: tx_ready=0 for 1000 cycles with byte 55 pending -> tx_data stays 55, req_ready[g]=0; the next byte is accepted the cycle tx_ready rises.
- MAX_BURST=4, req0 streams 10 bytes with no last while req2 is also valid -> after 4 bytes the grant moves to req2; req0 resumes on a later grant.
- Reset asserted mid-packet after 2 of 5 bytes -> next cycle tx_valid=0, busy=0, grant_id=0; no further bytes from the old packet appear.
- TAG_EN defined, req2 sends 1 byte 7A -> tx sees F2 then 7A.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter.
//   byte_t       : one byte of UART payload
//   arb_state_t  : arbiter FSM state; TAG keeps its encoding even when the
//                  tagging feature (UART_TX_ARBITER_TAG_EN) is compiled out
//   TAG_PREFIX   : upper nibble of a stream tag byte
//   make_tag()   : builds the tag byte {TAG_PREFIX, requester id}
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        SEND = 2'd2
    } arb_state_t;

    localparam logic [3:0] TAG_PREFIX = 4'hF;

    function automatic byte_t make_tag(input logic [3:0] id);
        return {TAG_PREFIX, id};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts at ptr_i and
// wraps modulo N; the first asserted request wins. N need not be a power of two.
//   req_i    in  N      request vector
//   ptr_i    in  IDX_W  index with highest priority this cycle
//   winner_o out IDX_W  winning index (0 when no hit)
//   hit_o    out 1      at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             hit_o
);

    // One spare bit so ptr + offset can exceed N before the explicit wrap.
    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] sel;

    always_comb begin
        winner_o = '0;
        hit_o    = 1'b0;
        sum      = '0;
        sel      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            sel = sum[IDX_W-1:0];
            if (!hit_o && req_i[sel]) begin
                hit_o    = 1'b1;
                winner_o = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter byte stream between N_REQ requesters with
// packet-granular round-robin arbitration. A grant lasts until the requester's
// last byte or until MAX_BURST bytes have been sent. A one-entry output
// register sits in front of the transmitter (1 cycle of added latency).
//
// Optional build macro UART_TX_ARBITER_TAG_EN: each grant is preceded by a tag
// byte (8'hF0 | grant_id) so the host can demultiplex the streams.
//
// Handshake: a byte moves across any valid/ready pair on a rising clock edge
// where both valid and ready are high; valid must not depend on ready, and the
// sender holds its byte stable until it moves.
//
// Ports:
//   clock, reset    in   clock, synchronous active-high reset
//   req_data        in   N_REQ x 8  byte from each requester
//   req_valid       in   N_REQ      requester i has a byte
//   req_last        in   N_REQ      requester i's byte ends its packet
//   req_ready       out  N_REQ      requester i's byte accepted this cycle
//   tx_data         out  8          byte to transmitter
//   tx_valid        out  1          tx_data valid
//   tx_ready        in   1          transmitter accepts
//   grant_id        out  GID_W      current or last granted requester
//   busy            out  1          FSM not idle or output register full
//   dbg_state       out  arb_state_t  FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ     = 3,
    parameter  int MAX_BURST = 64,
    localparam int GID_W     = $clog2(N_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0][7:0] req_data,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [GID_W-1:0]      grant_id,
    output logic                  busy,
    output arb_state_t            dbg_state
);

    arb_state_t       state_q, state_d;
    logic [GID_W-1:0] rr_ptr_q;
    logic [GID_W-1:0] grant_q;
    logic [CNT_W-1:0] burst_cnt_q;
    byte_t            tx_data_q;
    logic             tx_valid_q;

    logic             reg_free;
    logic [GID_W-1:0] pick_winner;
    logic             pick_hit;
    logic             accept;
    logic             rel_pkt;
    logic             load_en;
    byte_t            load_byte;
    logic [GID_W-1:0] next_ptr;

    // The register can take a new byte in the same cycle it drains.
    assign reg_free = !tx_valid_q || tx_ready;

    assign next_ptr = (grant_q == GID_W'(N_REQ - 1)) ? '0 : grant_q + GID_W'(1);

    rr_pick #(.N(N_REQ)) u_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_winner),
        .hit_o    (pick_hit)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_hit) begin
                grant_q     <= pick_winner;
                burst_cnt_q <= '0;
            end
            if (accept) begin
                burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            end
            if (rel_pkt) begin
                rr_ptr_q <= next_ptr;
            end
            if (load_en) begin
                tx_data_q  <= load_byte;
                tx_valid_q <= 1'b1;
            end else if (tx_ready) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
`ifdef UART_TX_ARBITER_TAG_EN
                    state_d = TAG;
`else
                    state_d = SEND;
`endif
                end
            end
            TAG: begin
`ifdef UART_TX_ARBITER_TAG_EN
                if (reg_free) begin
                    state_d = SEND;
                end
`else
                state_d = IDLE;
`endif
            end
            SEND: begin
                if (rel_pkt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / control logic.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        rel_pkt   = 1'b0;
        load_en   = 1'b0;
        load_byte = req_data[grant_q];
        case (state_q)
            SEND: begin
                req_ready[grant_q] = reg_free;
                accept    = reg_free && req_valid[grant_q];
                // Forced release once this accept makes MAX_BURST bytes.
                rel_pkt   = accept && (req_last[grant_q] ||
                                       burst_cnt_q == CNT_W'(MAX_BURST - 1));
                load_en   = accept;
            end
`ifdef UART_TX_ARBITER_TAG_EN
            TAG: begin
                load_en   = reg_free;
                load_byte = make_tag(4'(grant_q));
            end
`endif
            default: ;
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE) || tx_valid_q;
    assign dbg_state = state_q;

endmodule
